// File: rtl/ts_chs_compl_mc_pkg.sv
// Shared types for the multi-channel TX timestamp completion block.
package ts_chs_compl_mc_pkg;

    localparam int CPL_FP_W = 20;
    localparam int CPL_TS_W = 96;

    typedef enum logic [1:0] {
        CPL_OK  = 2'b00,
        CPL_TMO = 2'b01
    } cpl_status_e;

    typedef struct packed {
        logic [CPL_FP_W-1:0] fp;
        logic [CPL_TS_W-1:0] ts;
        cpl_status_e         status;
    } cpl_rec_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } ch_state_e;

    function automatic int rr_next(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ts_fp_fifo.sv
// Per-channel pending fingerprint FIFO with head-of-queue age counter.
module ts_fp_fifo
    import ts_chs_compl_mc_pkg::*;
#(
    parameter int FP_W  = 20,
    parameter int DEPTH = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [FP_W-1:0]  i_fp,
    input  logic             i_pop,
    input  logic             i_age_en,
    output logic [FP_W-1:0]  o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf,
    output logic [TMO_W-1:0] o_age
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

    logic [FP_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             r_full;
    logic             r_ovf;
    logic [TMO_W-1:0] r_age;
    logic             w_push;
    logic             w_pop;

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_pop     = i_pop && (r_cnt != '0);
    assign w_push    = i_push && ((r_cnt != L_FULL) || w_pop);
    assign w_cnt_nxt = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_fp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
            r_age  <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == L_FULL);
            if (i_push && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_pop || !i_age_en) begin
                r_age <= '0;
            end else begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_full  = r_full;
    assign o_ovf   = r_ovf;
    assign o_age   = r_age;

endmodule

// File: rtl/ts_chs_compl_mc.sv
// Multi-channel TX timestamp completion: per-channel match/timeout, RR output.
// Drop counters are built only when TS_CHS_COMPL_MC_STATS_EN is defined.
module ts_chs_compl_mc
    import ts_chs_compl_mc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int FP_W   = CPL_FP_W,
    parameter int TS_W   = CPL_TS_W,
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 16,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       i_req_valid,
    input  logic [NUM_CH*FP_W-1:0]  i_req_fingerprint,
    output logic [NUM_CH-1:0]       o_req_full,
    input  logic [NUM_CH-1:0]       i_ts_valid,
    input  logic [NUM_CH*FP_W-1:0]  i_ts_fingerprint,
    input  logic [NUM_CH*TS_W-1:0]  i_ts_data,
    input  logic [TMO_W-1:0]        i_tmo_cycles,
    output logic                    o_cpl_valid,
    input  logic                    i_cpl_ready,
    output logic [CH_W-1:0]         o_cpl_ch,
    output logic [FP_W-1:0]         o_cpl_fingerprint,
    output logic [TS_W-1:0]         o_cpl_data,
    output logic [1:0]              o_cpl_status,
    output logic [NUM_CH-1:0]       o_req_ovf,
    output logic [NUM_CH*CNT_W-1:0] o_drop_cnt
);

    if (FP_W != CPL_FP_W || TS_W != CPL_TS_W) begin : g_bad_width
        $error("cpl_rec_t widths do not match FP_W/TS_W");
    end

    logic [NUM_CH-1:0] w_hold;
    cpl_rec_t          w_slot [NUM_CH];
    logic              w_gvld;
    logic [CH_W-1:0]   w_gidx;
    logic [CH_W-1:0]   w_idx;
    logic              w_take;
    logic [CH_W-1:0]   r_ptr;
    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    cpl_rec_t          r_out;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_e        r_state;
        ch_state_e        w_state_nxt;
        cpl_rec_t         r_slot;
        logic [FP_W-1:0]  w_head;
        logic [FP_W-1:0]  w_ts_fp;
        logic [TMO_W-1:0] w_age;
        logic             w_empty;
        logic             w_hit;
        logic             w_tmo;
        logic             w_pop;
        logic             w_grant;

        assign w_ts_fp = i_ts_fingerprint[c*FP_W +: FP_W];
        assign w_hit   = i_ts_valid[c] && (r_state == WAIT)
                      && (w_ts_fp == w_head);
        assign w_tmo   = (r_state == WAIT) && (i_tmo_cycles != '0)
                      && (w_age == i_tmo_cycles - TMO_W'(1));
        assign w_pop   = w_hit || w_tmo;
        assign w_grant = w_take && (w_gidx == CH_W'(c));

        assign w_hold[c] = (r_state == HOLD);
        assign w_slot[c] = r_slot;

        ts_fp_fifo #(
            .FP_W  (FP_W),
            .DEPTH (DEPTH),
            .TMO_W (TMO_W)
        ) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_push   (i_req_valid[c]),
            .i_fp     (i_req_fingerprint[c*FP_W +: FP_W]),
            .i_pop    (w_pop),
            .i_age_en (r_state == WAIT),
            .o_head   (w_head),
            .o_empty  (w_empty),
            .o_full   (o_req_full[c]),
            .o_ovf    (o_req_ovf[c]),
            .o_age    (w_age)
        );

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            unique case (r_state)
                IDLE: begin
                    if (i_req_valid[c]) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (w_pop) begin
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (w_grant) begin
                        w_state_nxt = (!w_empty || i_req_valid[c]) ? WAIT : IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // A match beats a timeout landing on the same cycle.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_slot <= '0;
            end else if (w_pop) begin
                r_slot.fp     <= w_head;
                r_slot.ts     <= w_hit ? i_ts_data[c*TS_W +: TS_W] : '0;
                r_slot.status <= w_hit ? CPL_OK : CPL_TMO;
            end
        end

`ifdef TS_CHS_COMPL_MC_STATS_EN
        logic [CNT_W-1:0] r_drop;
        logic             w_drop;

        assign w_drop = i_ts_valid[c] && !w_hit;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_drop <= '0;
            end else if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end

        assign o_drop_cnt[c*CNT_W +: CNT_W] = r_drop;
`else
        assign o_drop_cnt[c*CNT_W +: CNT_W] = '0;
`endif
    end

    always_comb begin
        w_gvld = 1'b0;
        w_gidx = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_gvld && w_hold[w_idx]) begin
                w_gvld = 1'b1;
                w_gidx = w_idx;
            end
        end
    end

    assign w_take = w_gvld && (!r_out_valid || i_cpl_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out       <= '0;
        end else begin
            if (w_take) begin
                r_ptr       <= CH_W'(rr_next(int'(w_gidx), NUM_CH));
                r_out_valid <= 1'b1;
                r_out_ch    <= w_gidx;
                r_out       <= w_slot[w_gidx];
            end else if (i_cpl_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_cpl_valid       = r_out_valid;
    assign o_cpl_ch          = r_out_ch;
    assign o_cpl_fingerprint = r_out.fp;
    assign o_cpl_data        = r_out.ts;
    assign o_cpl_status      = r_out.status;

endmodule

// File: tb/tb_ts_chs_compl_mc.sv
// Scoreboard bench for ts_chs_compl_mc with directed vectors.
module tb_ts_chs_compl_mc;

    localparam int NUM_CH = 2;
    localparam int FP_W   = 20;
    localparam int TS_W   = 96;
    localparam int DEPTH  = 8;
    localparam int TMO_W  = 16;
    localparam int CNT_W  = 16;

`ifdef TS_CHS_COMPL_MC_STATS_EN
    localparam logic [CNT_W-1:0] EXP_DROP3 = 16'd3;
`else
    localparam logic [CNT_W-1:0] EXP_DROP3 = 16'd0;
`endif

    typedef struct {
        int             ch;
        logic [FP_W-1:0] fp;
        logic [TS_W-1:0] ts;
        logic [1:0]      st;
        int             cyc;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH*FP_W-1:0]  req_fp;
    logic [NUM_CH-1:0]       req_full;
    logic [NUM_CH-1:0]       ts_valid;
    logic [NUM_CH*FP_W-1:0]  ts_fp;
    logic [NUM_CH*TS_W-1:0]  ts_data;
    logic [TMO_W-1:0]        tmo;
    logic                    cpl_valid;
    logic                    ready;
    logic [0:0]              cpl_ch;
    logic [FP_W-1:0]         cpl_fp;
    logic [TS_W-1:0]         cpl_data;
    logic [1:0]              cpl_st;
    logic [NUM_CH-1:0]       req_ovf;
    logic [NUM_CH*CNT_W-1:0] drop_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e;

    ts_chs_compl_mc #(
        .NUM_CH (NUM_CH),
        .FP_W   (FP_W),
        .TS_W   (TS_W),
        .DEPTH  (DEPTH),
        .TMO_W  (TMO_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_req_valid       (req_valid),
        .i_req_fingerprint (req_fp),
        .o_req_full        (req_full),
        .i_ts_valid        (ts_valid),
        .i_ts_fingerprint  (ts_fp),
        .i_ts_data         (ts_data),
        .i_tmo_cycles      (tmo),
        .o_cpl_valid       (cpl_valid),
        .i_cpl_ready       (ready),
        .o_cpl_ch          (cpl_ch),
        .o_cpl_fingerprint (cpl_fp),
        .o_cpl_data        (cpl_data),
        .o_cpl_status      (cpl_st),
        .o_req_ovf         (req_ovf),
        .o_drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    function automatic void add_exp(int ch, logic [FP_W-1:0] fp,
                                    logic [TS_W-1:0] ts, logic [1:0] st,
                                    int c);
        exp_t x;
        x.ch = ch; x.fp = fp; x.ts = ts; x.st = st; x.cyc = c;
        q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1 && cpl_valid === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL cpl_unexpected ch=%0d fp=%h st=%0d exp=none",
                         cpl_ch, cpl_fp, cpl_st);
            end else begin
                e = q[0];
                if (cpl_ch !== 1'(e.ch) || cpl_fp !== e.fp ||
                    cpl_data !== e.ts || cpl_st !== e.st) begin
                    n_err++;
                    $display("FAIL cpl act ch=%0d fp=%h ts=%h st=%0d exp ch=%0d fp=%h ts=%h st=%0d",
                             cpl_ch, cpl_fp, cpl_data, cpl_st,
                             e.ch, e.fp, e.ts, e.st);
                end
                if (ready) begin
                    if (e.cyc >= 0) begin
                        n_vec++;
                        if (cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL cpl_cycle fp=%h act=%0d exp=%0d",
                                     e.fp, cyc, e.cyc);
                        end
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = '0;
        ts_valid  = '0;
    endtask

    task automatic set_req(int ch, logic [FP_W-1:0] fp);
        req_valid[ch] = 1'b1;
        req_fp[ch*FP_W +: FP_W] = fp;
    endtask

    task automatic set_ts(int ch, logic [FP_W-1:0] fp, logic [TS_W-1:0] d);
        ts_valid[ch] = 1'b1;
        ts_fp[ch*FP_W +: FP_W] = fp;
        ts_data[ch*TS_W +: TS_W] = d;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        ts_valid  = '0;
        ready     = 1'b1;
        tmo       = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
    endtask

    task automatic drain(string nm);
        int k = 0;
        while ((q.size() != 0 || cpl_valid) && k < 200) begin
            step();
            k++;
        end
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        req_fp  = '0;
        ts_fp   = '0;
        ts_data = '0;
        reset_n = 1'b0;
        req_valid = '0;
        ts_valid  = '0;
        ready = 1'b1;
        tmo   = '0;
        #2;
        chk("rst_valid", 64'(cpl_valid), 64'd0);
        chk("rst_full", 64'(req_full), 64'd0);
        chk("rst_ovf", 64'(req_ovf), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        do_reset();

        // basic match, two-cycle latency
        set_req(0, 20'h00011);
        step();
        n = cyc;
        set_ts(0, 20'h00011, 96'h1234);
        add_exp(0, 20'h00011, 96'h1234, 2'b00, n + 2);
        step();
        drain("drain_basic");
        chk("drop_basic", 64'(drop_cnt), 64'd0);

        // simultaneous pair under stall, then round-robin order
        do_reset();
        ready = 1'b0;
        set_req(0, 20'h00201);
        set_req(1, 20'h00301);
        step();
        set_ts(0, 20'h00201, 96'hA201);
        set_ts(1, 20'h00301, 96'hB301);
        add_exp(0, 20'h00201, 96'hA201, 2'b00, -1);
        add_exp(1, 20'h00301, 96'hB301, 2'b00, -1);
        step();
        repeat (6) step();
        ready = 1'b1;
        q[0].cyc = cyc;
        q[1].cyc = cyc + 1;
        drain("drain_pair1");
        set_req(0, 20'h00202);
        step();
        set_ts(0, 20'h00202, 96'hA202);
        add_exp(0, 20'h00202, 96'hA202, 2'b00, -1);
        step();
        drain("drain_single");
        set_req(0, 20'h00203);
        set_req(1, 20'h00302);
        step();
        n = cyc;
        set_ts(0, 20'h00203, 96'hA203);
        set_ts(1, 20'h00302, 96'hB302);
        add_exp(1, 20'h00302, 96'hB302, 2'b00, n + 2);
        add_exp(0, 20'h00203, 96'hA203, 2'b00, n + 3);
        step();
        drain("drain_pair2");

        // timeout, and match on the timeout cycle
        do_reset();
        tmo = 16'd10;
        p = cyc;
        set_req(0, 20'h00AAA);
        add_exp(0, 20'h00AAA, 96'h0, 2'b01, p + 12);
        step();
        repeat (14) step();
        drain("drain_tmo");
        p = cyc;
        set_req(0, 20'h00BBB);
        step();
        repeat (9) step();
        set_ts(0, 20'h00BBB, 96'h5555);
        add_exp(0, 20'h00BBB, 96'h5555, 2'b00, p + 12);
        step();
        drain("drain_tmo_match");
        tmo = '0;

        // fill ch1 past DEPTH
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            set_req(1, 20'h00100 + 20'(i));
            step();
        end
        @(negedge clk);
        chk("full_at_depth", 64'(req_full), 64'h2);
        chk("ovf_ch1", 64'(req_ovf), 64'h2);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            set_ts(1, 20'h00100 + 20'(i), 96'hA000 + 96'(i));
            add_exp(1, 20'h00100 + 20'(i), 96'hA000 + 96'(i), 2'b00, -1);
            repeat (3) step();
        end
        drain("drain_fill");
        chk("full_cleared", 64'(req_full), 64'h0);
        set_ts(1, 20'h00108, 96'hBAD);
        step();
        drain("drain_overflowed_fp");

        // drops: empty, mismatch, overrun while held
        do_reset();
        ready = 1'b0;
        set_ts(0, 20'h00099, 96'h1);
        step();
        set_req(0, 20'h00055);
        step();
        set_req(0, 20'h00077);
        step();
        set_req(0, 20'h00088);
        step();
        set_ts(0, 20'h00066, 96'h2);
        step();
        set_ts(0, 20'h00055, 96'hD55);
        add_exp(0, 20'h00055, 96'hD55, 2'b00, -1);
        repeat (3) step();
        set_ts(0, 20'h00077, 96'hD77);
        add_exp(0, 20'h00077, 96'hD77, 2'b00, -1);
        repeat (2) step();
        set_ts(0, 20'h00088, 96'h3);
        repeat (2) step();
        @(negedge clk);
        chk("drop_ch0", 64'(drop_cnt[CNT_W-1:0]), 64'(EXP_DROP3));
        chk("drop_ch1", 64'(drop_cnt[2*CNT_W-1:CNT_W]), 64'd0);
        chk("ovf_none", 64'(req_ovf), 64'd0);
        step();
        ready = 1'b1;
        drain("drain_drops");
        set_ts(0, 20'h00088, 96'hD88);
        add_exp(0, 20'h00088, 96'hD88, 2'b00, -1);
        step();
        drain("drain_head_kept");

        // reset with pending and held work
        do_reset();
        ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            set_req(1, 20'h00400 + 20'(i));
            step();
        end
        for (int i = 1; i <= 4; i++) begin
            set_req(0, 20'h00500 + 20'(i));
            step();
        end
        set_ts(0, 20'h00501, 96'hE1);
        add_exp(0, 20'h00501, 96'hE1, 2'b00, -1);
        repeat (2) step();
        set_ts(0, 20'h00502, 96'hE2);
        repeat (2) step();
        chk("pre_rst_ovf", 64'(req_ovf), 64'h2);
        chk("pre_rst_valid", 64'(cpl_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 64'(cpl_valid), 64'd0);
        chk("mid_rst_full", 64'(req_full), 64'd0);
        chk("mid_rst_ovf", 64'(req_ovf), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        chk("mid_rst_fp", 64'(cpl_fp), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ready = 1'b1;
        step();
        set_ts(0, 20'h00503, 96'hE3);
        step();
        repeat (20) step();
        chk("post_rst_valid", 64'(cpl_valid), 64'd0);
        chk("post_rst_q", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
